// File: rtl/digit_stroke_sequencer.sv
// Seven-segment stroke sequencer: walks segments a-g of a latched digit and drives the
// horizontal/vertical line generators one 2-pixel-thick stroke at a time. Define DIGIT_HEX_EN for hex glyphs A-F.
module digit_stroke_sequencer #(
  parameter int SEG_LEN = 5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] digit,
  input  logic [4:0] x,
  input  logic [4:0] y,
  output logic [4:0] line_x,
  output logic [4:0] line_y,
  output logic [4:0] line_dist,
  output logic       line_vert,
  output logic       line_en,
  output logic       line_resetn,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] SEG_L     = 5'(SEG_LEN);
  localparam logic [4:0] SEG_2L    = 5'(2 * SEG_LEN);
  localparam logic [4:0] DRAW_LAST = 5'(2 * SEG_LEN + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    CLEAR  = 3'd2,
    DRAW   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic [4:0] cnt_reg, cnt_next;
  logic [3:0] digit_reg;
  logic [4:0] x_reg, y_reg;
  logic [4:0] line_x_reg, line_y_reg;
  logic       line_vert_reg;

  logic [7:0] mask;
  logic [4:0] seg_x, seg_y;
  logic       seg_vert;
  logic       accept;
  logic       load_seg;

  // Bit 0 = segment a ... bit 6 = segment g; bit 7 stays 0 so idx 7 is never lit.
  always_comb begin
    mask = 8'h00;
    case (digit_reg)
      4'd0: mask = 8'h3F;
      4'd1: mask = 8'h06;
      4'd2: mask = 8'h5B;
      4'd3: mask = 8'h4F;
      4'd4: mask = 8'h66;
      4'd5: mask = 8'h6D;
      4'd6: mask = 8'h7D;
      4'd7: mask = 8'h07;
      4'd8: mask = 8'h7F;
      4'd9: mask = 8'h6F;
`ifdef DIGIT_HEX_EN
      4'd10: mask = 8'h77;
      4'd11: mask = 8'h7C;
      4'd12: mask = 8'h39;
      4'd13: mask = 8'h5E;
      4'd14: mask = 8'h79;
      4'd15: mask = 8'h71;
`endif
      default: mask = 8'h00;
    endcase
  end

  // Stroke origin for the current segment; 5-bit sums wrap on purpose.
  always_comb begin
    seg_x    = x_reg;
    seg_y    = y_reg;
    seg_vert = 1'b0;
    case (idx_reg)
      3'd1: begin seg_x = x_reg + SEG_L - 5'd1; seg_vert = 1'b1; end
      3'd2: begin seg_x = x_reg + SEG_L - 5'd1; seg_y = y_reg + SEG_L; seg_vert = 1'b1; end
      3'd3: begin seg_y = y_reg + SEG_2L; end
      3'd4: begin seg_y = y_reg + SEG_L; seg_vert = 1'b1; end
      3'd5: begin seg_vert = 1'b1; end
      3'd6: begin seg_y = y_reg + SEG_L; end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    load_seg   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          idx_next   = 3'd0;
          state_next = SELECT;
        end
      end
      SELECT: begin
        if (idx_reg == 3'd7) begin
          state_next = DONE;
        end else if (mask[idx_reg]) begin
          load_seg   = 1'b1;
          state_next = CLEAR;
        end else begin
          // The last segment goes straight to DONE so no extra SELECT cycle is spent on idx 7.
          idx_next   = idx_reg + 3'd1;
          state_next = (idx_reg == 3'd6) ? DONE : SELECT;
        end
      end
      CLEAR: begin
        cnt_next   = 5'd0;
        state_next = DRAW;
      end
      DRAW: begin
        if (cnt_reg == DRAW_LAST) begin
          idx_next   = idx_reg + 3'd1;
          state_next = (idx_reg == 3'd6) ? DONE : SELECT;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      idx_reg       <= 3'd0;
      cnt_reg       <= 5'd0;
      digit_reg     <= 4'd0;
      x_reg         <= 5'd0;
      y_reg         <= 5'd0;
      line_x_reg    <= 5'd0;
      line_y_reg    <= 5'd0;
      line_vert_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        digit_reg <= digit;
        x_reg     <= x;
        y_reg     <= y;
      end
      if (load_seg) begin
        line_x_reg    <= seg_x;
        line_y_reg    <= seg_y;
        line_vert_reg <= seg_vert;
      end
    end
  end

  assign line_x      = line_x_reg;
  assign line_y      = line_y_reg;
  assign line_vert   = line_vert_reg;
  assign line_dist   = SEG_L;
  assign line_en     = (state_reg == DRAW);
  assign line_resetn = (state_reg == DRAW);
  assign plot        = (state_reg == DRAW);
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);

endmodule
